// File: rtl/rca16_sched_pkg.sv
// Shared constants and types for the round-robin scheduler around the 16-bit ripple-carry adder.
package rca16_sched_pkg;

    localparam int RCA_W        = 16;
    localparam int DEFAULT_NREQ = 4;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  g,
    output logic            found
);

    always_comb begin
        int idx;
        grant = '0;
        g     = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                g          = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rca16_rr_sched.sv
// Round-robin scheduler sharing one external 16-bit adder among NREQ requesters.
// Optional per-requester grant counters are built when RCA_SCHED_STATS_EN is defined.
module rca16_rr_sched
    import rca16_sched_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = RCA_W,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id
`ifdef RCA_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);

    slot_state_e       state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic [IDW-1:0]    id_q;

    logic [NREQ-1:0]   pickOneHot;
    logic [IDW-1:0]    g;
    logic              found;
    logic              canIssue;
    logic              grantNow;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (pickOneHot),
        .g         (g),
        .found     (found)
    );

    assign canIssue = (state_q == S_EMPTY) || rsp_ready;
    assign grantNow = canIssue && found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant always fills the slot, even when it drains in the same cycle.
    always_comb begin
        state_d = state_q;
        if (grantNow) begin
            state_d = S_FULL;
        end else if (state_q == S_FULL && rsp_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_comb begin
        rsp_valid = (state_q == S_FULL);
        req_ready = grantNow ? pickOneHot : '0;
        add_a     = grantNow ? req_a[int'(g)*W +: W] : '0;
        add_b     = grantNow ? req_b[int'(g)*W +: W] : '0;
    end

    assign ptr_d = (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= '0;
        end else if (grantNow) begin
            ptr_q  <= ptr_d;
            sum_q  <= add_sum;
            cout_q <= add_cout;
            id_q   <= g;
        end
    end

    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_id   = id_q;

`ifdef RCA_SCHED_STATS_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (grantNow && cnt_q[g] != CNT_SAT) begin
            cnt_q[g] <= cnt_q[g] + 16'd1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt_out
        assign grant_cnt[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_rca16_rr_sched.sv
// Directed testbench for rca16_rr_sched with an exact 16-bit adder model; stats checks need RCA_SCHED_STATS_EN.
module tb_rca16_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rstN;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ*W-1:0] reqA;
    logic [NREQ*W-1:0] reqB;
    logic [W-1:0]      addA;
    logic [W-1:0]      addB;
    logic [W-1:0]      addSum;
    logic              addCout;
    logic              rspValid;
    logic              rspReady;
    logic [W-1:0]      rspSum;
    logic              rspCout;
    logic [IDW-1:0]    rspId;
`ifdef RCA_SCHED_STATS_EN
    logic [NREQ*16-1:0] grantCnt;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB};

    rca16_rr_sched #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_a     (reqA),
        .req_b     (reqB),
        .add_a     (addA),
        .add_b     (addB),
        .add_sum   (addSum),
        .add_cout  (addCout),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_sum   (rspSum),
        .rsp_cout  (rspCout),
        .rsp_id    (rspId)
`ifdef RCA_SCHED_STATS_EN
        ,
        .grant_cnt (grantCnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] valid, input logic ready);
        rstN     = rst;
        reqValid = valid;
        rspReady = ready;
    endtask

    task automatic setOperands(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        reqA[idx*W +: W] = a;
        reqB[idx*W +: W] = b;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResponse(input string tag, input logic valid, input logic [W-1:0] sum,
                                 input logic cout, input logic [IDW-1:0] id);
        checkOutput({tag, ".valid"}, 32'(rspValid), 32'(valid));
        checkOutput({tag, ".sum"},   32'(rspSum),   32'(sum));
        checkOutput({tag, ".cout"},  32'(rspCout),  32'(cout));
        checkOutput({tag, ".id"},    32'(rspId),    32'(id));
    endtask

    logic [NREQ-1:0] rrReady [5];
    logic [W-1:0]    rrSum   [5];
    logic [IDW-1:0]  rrId    [5];

    initial begin
        rrReady = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rrSum   = '{16'h1000, 16'h2001, 16'h3002, 16'h4003, 16'h1000};
        rrId    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reqA = '0;
        reqB = '0;
        applyStimulus(1'b0, 4'b0000, 1'b1);
        stepCycle();
        stepCycle();
        checkResponse("reset", 1'b0, 16'h0000, 1'b0, 2'd0);
        checkOutput("reset.req_ready", 32'(reqReady), 32'h0);

        // Round robin with every requester valid; a_i = 0x1000*(i+1), b_i = i.
        for (int i = 0; i < NREQ; i++) begin
            setOperands(i, W'(16'h1000 * (i + 1)), W'(i));
        end
        applyStimulus(1'b1, 4'b1111, 1'b1);
        #1;
        checkOutput("rr.first_ready", 32'(reqReady), 32'h1);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("rr%0d.req_ready", k), 32'(reqReady), 32'(rrReady[k]));
            stepCycle();
            checkOutput($sformatf("rr%0d.id", k),  32'(rspId),  32'(rrId[k]));
            checkOutput($sformatf("rr%0d.sum", k), 32'(rspSum), 32'(rrSum[k]));
        end

        // ptr is now 1; only requester 2 presents work.
        setOperands(2, 16'h1234, 16'h0FF0);
        applyStimulus(1'b1, 4'b0100, 1'b1);
        #1;
        checkOutput("single.add_a", 32'(addA), 32'h1234);
        checkOutput("single.add_b", 32'(addB), 32'h0FF0);
        stepCycle();
        checkResponse("single", 1'b1, 16'h2224, 1'b0, 2'd2);

        applyStimulus(1'b1, 4'b0000, 1'b1);
        #1;
        checkOutput("idle.add_a", 32'(addA), 32'h0);
        checkOutput("idle.req_ready", 32'(reqReady), 32'h0);
        stepCycle();
        checkResponse("drain", 1'b0, 16'h2224, 1'b0, 2'd2);

        setOperands(0, 16'hFFFF, 16'h0001);
        applyStimulus(1'b1, 4'b0001, 1'b1);
        stepCycle();
        checkResponse("overflow", 1'b1, 16'h0000, 1'b1, 2'd0);

        // Slot full and consumer stalled: nothing may be granted, ptr stays at 1.
        setOperands(1, 16'h0101, 16'h0202);
        setOperands(3, 16'h8000, 16'h8001);
        applyStimulus(1'b1, 4'b1010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("stall%0d.req_ready", k), 32'(reqReady), 32'h0);
            stepCycle();
            checkResponse($sformatf("stall%0d", k), 1'b1, 16'h0000, 1'b1, 2'd0);
        end
        rspReady = 1'b1;
        #1;
        checkOutput("unstall.req_ready", 32'(reqReady), 32'h2);
        stepCycle();
        checkResponse("unstall", 1'b1, 16'h0303, 1'b0, 2'd1);
        applyStimulus(1'b1, 4'b1000, 1'b1);
        stepCycle();
        checkResponse("req3", 1'b1, 16'h0001, 1'b1, 2'd3);

        // Reset while a response is pending and stalled.
        applyStimulus(1'b0, 4'b1111, 1'b0);
        stepCycle();
        checkResponse("midreset", 1'b0, 16'h0000, 1'b0, 2'd0);
        for (int i = 0; i < NREQ; i++) begin
            setOperands(i, W'(16'h1000 * (i + 1)), W'(i));
        end
        applyStimulus(1'b1, 4'b1111, 1'b1);
        #1;
        checkOutput("postreset.req_ready", 32'(reqReady), 32'h1);
        stepCycle();
        checkResponse("postreset", 1'b1, 16'h1000, 1'b0, 2'd0);

`ifdef RCA_SCHED_STATS_EN
        applyStimulus(1'b0, 4'b0000, 1'b1);
        stepCycle();
        checkOutput("stats.reset", 32'(grantCnt[15:0]), 32'h0);
        applyStimulus(1'b1, 4'b0001, 1'b1);
        for (int k = 0; k < 70000; k++) begin
            stepCycle();
        end
        checkOutput("stats.cnt0", 32'(grantCnt[15:0]),  32'hFFFF);
        checkOutput("stats.cnt1", 32'(grantCnt[31:16]), 32'h0);
        checkOutput("stats.cnt2", 32'(grantCnt[47:32]), 32'h0);
        checkOutput("stats.cnt3", 32'(grantCnt[63:48]), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
